// File: rtl/axi_mst_rd_arb_pkg.sv
// Shared constants and FSM encoding for the AXI master read-side arbiter.
// The write-side arbiter is expected to pick up the same widths from here.
package axi_mst_rd_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;

  localparam int unsigned AXI_ID_W    = 4;
  localparam int unsigned AXI_ADDR_W  = 32;
  localparam int unsigned AXI_LEN_W   = 8;
  localparam int unsigned AXI_DATA_W  = 32;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

endpackage

// File: rtl/axi_mst_rd_arb_if.sv
// Requester-side and read-controller-side signals of the read arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface axi_mst_rd_arb_if
  import axi_mst_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ID_W    = AXI_ID_W,
  parameter int unsigned ADDR_W  = AXI_ADDR_W,
  parameter int unsigned LEN_W   = AXI_LEN_W,
  parameter int unsigned DATA_W  = AXI_DATA_W
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*ID_W-1:0]        req_id;
  logic [NUM_REQ*ADDR_W-1:0]      req_addr;
  logic [NUM_REQ*LEN_W-1:0]       req_len;
  logic [NUM_REQ*AXI_SIZE_W-1:0]  req_size;
  logic [NUM_REQ*AXI_BURST_W-1:0] req_burst;

  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;
  logic                           busy;

  logic                           rd_req_en;
  logic [ID_W-1:0]                rd_id;
  logic [ADDR_W-1:0]              rd_base_addr;
  logic [LEN_W-1:0]               rd_len;
  logic [AXI_SIZE_W-1:0]          rd_size;
  logic [AXI_BURST_W-1:0]         rd_burst;
  logic                           rd_result_en;
  logic [DATA_W-1:0]              rd_result_data;

  modport master (
    input  req_valid, req_id, req_addr, req_len, req_size, req_burst,
    input  rd_result_en, rd_result_data,
    output req_ready, rsp_valid, rsp_data, busy,
    output rd_req_en, rd_id, rd_base_addr, rd_len, rd_size, rd_burst
  );

  modport slave (
    output req_valid, req_id, req_addr, req_len, req_size, req_burst,
    output rd_result_en, rd_result_data,
    input  req_ready, rsp_valid, rsp_data, busy,
    input  rd_req_en, rd_id, rd_base_addr, rd_len, rd_size, rd_burst
  );

endinterface

// File: rtl/axi_mst_rd_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module axi_mst_rd_arb_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  int unsigned idx;

  assign any_req = |req;

  // Scan farthest-first so the nearest requester after rr_ptr is written last and wins.
  always_comb begin
    idx       = 0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (32'(rr_ptr) + 32'(k)) % NUM_REQ;
      if (req[idx[IDX_W-1:0]]) begin
        grant_idx = idx[IDX_W-1:0];
      end
    end
    grant = any_req ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/axi_mst_rd_arb.sv
// Serialises NUM_REQ read requesters onto one single-outstanding AXI read controller
// and routes each last-beat result back to the requester that owns it.
module axi_mst_rd_arb
  import axi_mst_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ),
  parameter int unsigned ID_W    = AXI_ID_W,
  parameter int unsigned ADDR_W  = AXI_ADDR_W,
  parameter int unsigned LEN_W   = AXI_LEN_W,
  parameter int unsigned DATA_W  = AXI_DATA_W
) (
  input logic               clk,
  input logic               rst_n,
  axi_mst_rd_arb_if.master  bus
);

  state_e state_q, state_d;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   any_req;
  logic                   grant_take;
  logic                   rsp_take;

  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       grant_idx_q;
  logic [ID_W-1:0]        rd_id_q;
  logic [ADDR_W-1:0]      rd_addr_q;
  logic [LEN_W-1:0]       rd_len_q;
  logic [AXI_SIZE_W-1:0]  rd_size_q;
  logic [AXI_BURST_W-1:0] rd_burst_q;
  logic [NUM_REQ-1:0]     rsp_valid_q;
  logic [DATA_W-1:0]      rsp_data_q;

  axi_mst_rd_arb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign grant_take = (state_q == StIdle) && any_req;
  assign rsp_take   = (state_q == StWait) && bus.rd_result_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (bus.rd_result_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.busy      = 1'b0;
    bus.rd_req_en = 1'b0;
    unique case (state_q)
      StIdle:  bus.req_ready = grant;
      StIssue: begin
        bus.busy      = 1'b1;
        bus.rd_req_en = 1'b1;
      end
      StWait:  bus.busy = 1'b1;
      default: ;
    endcase
  end

  // Payload is captured only on grant so rd_* hold the last granted request between bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      rd_id_q     <= '0;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
      rd_size_q   <= '0;
      rd_burst_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (grant_take) begin
        grant_idx_q <= grant_idx;
        rr_ptr_q    <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        rd_id_q     <= bus.req_id[grant_idx*ID_W +: ID_W];
        rd_addr_q   <= bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
        rd_len_q    <= bus.req_len[grant_idx*LEN_W +: LEN_W];
        rd_size_q   <= bus.req_size[grant_idx*AXI_SIZE_W +: AXI_SIZE_W];
        rd_burst_q  <= bus.req_burst[grant_idx*AXI_BURST_W +: AXI_BURST_W];
      end
      if (rsp_take) begin
        rsp_valid_q[grant_idx_q] <= 1'b1;
        rsp_data_q               <= bus.rd_result_data;
      end
    end
  end

  assign bus.rd_id        = rd_id_q;
  assign bus.rd_base_addr = rd_addr_q;
  assign bus.rd_len       = rd_len_q;
  assign bus.rd_size      = rd_size_q;
  assign bus.rd_burst     = rd_burst_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_axi_mst_rd_arb.sv
// Self-checking bench for axi_mst_rd_arb: directed scenarios plus a random phase,
// all compared cycle by cycle against a transaction-level reference model.
module tb_axi_mst_rd_arb;
  import axi_mst_rd_arb_pkg::*;

  localparam int N  = 4;
  localparam int IW = AXI_ID_W;
  localparam int AW = AXI_ADDR_W;
  localparam int LW = AXI_LEN_W;
  localparam int DW = AXI_DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_mst_rd_arb_if bus ();

  axi_mst_rd_arb u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Requester-side stimulus and the payloads the bench itself offered.
  logic [N-1:0]  v;
  logic [IW-1:0] q_id    [N];
  logic [AW-1:0] q_addr  [N];
  logic [LW-1:0] q_len   [N];
  logic [2:0]    q_size  [N];
  logic [1:0]    q_burst [N];
  logic [N-1:0]  pv, pr;

  // Reference model: who owns the controller, how long since grant, what is expected.
  int            m_rr, m_owner, m_age, m_cnt;
  logic [N-1:0]  m_rsp;
  logic [DW-1:0] m_rsp_data;
  logic [IW-1:0] e_id;
  logic [AW-1:0] e_addr;
  logic [LW-1:0] e_len;
  logic [2:0]    e_size;
  logic [1:0]    e_burst;

  int       lat_min, lat_max, spur_mode;
  bit       cont_mode, rand_arr, fix_en;
  logic [DW-1:0] fix_data;
  int       last_granted, last_completed;
  int       grant_q[$];
  int       exp_order[5] = '{0, 1, 2, 3, 0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [LW-1:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    q_id[i] = id; q_addr[i] = addr; q_len[i] = len; q_size[i] = size; q_burst[i] = burst;
    bus.req_id[i*IW +: IW]   = id;
    bus.req_addr[i*AW +: AW] = addr;
    bus.req_len[i*LW +: LW]  = len;
    bus.req_size[i*3 +: 3]   = size;
    bus.req_burst[i*2 +: 2]  = burst;
    v[i] = 1'b1;
    bus.req_valid = v;
  endtask

  task automatic new_rand_req(input int i);
    set_req(i, IW'($urandom), $urandom, LW'($urandom), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 2)));
  endtask

  task automatic model_reset();
    m_rr = 0; m_owner = -1; m_age = 0; m_cnt = 0;
    m_rsp = '0; m_rsp_data = '0;
    e_id = '0; e_addr = '0; e_len = '0; e_size = '0; e_burst = '0;
    v = '0; pv = '0; pr = '0;
    bus.req_valid = '0;
    bus.rd_result_en = 1'b0;
  endtask

  // One clock: drive the controller side, compare every output, advance the model.
  task automatic run_cycle();
    logic          res_en;
    logic [DW-1:0] res_data;
    logic [N-1:0]  exp_ready;
    int            g;
    res_data = $urandom;
    if (m_owner >= 0 && m_age >= 2) begin
      res_en = (m_cnt == 0);
      if (m_cnt == 0) begin
        if (fix_en) res_data = fix_data;
      end else begin
        m_cnt--;
      end
    end else begin
      res_en = (spur_mode == 2) || (spur_mode == 1 && $urandom_range(0, 2) == 0);
    end
    bus.rd_result_en   = res_en;
    bus.rd_result_data = res_data;
    #1;
    assert ((pv & ~pr & ~v) == '0) else begin
      n_fail++;
      $error("FAIL proto_hold: observed %b expected 0000", pv & ~pr & ~v);
    end
    g = (m_owner < 0) ? pick(v, m_rr) : -1;
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready",    64'(bus.req_ready),    64'(exp_ready));
    check("rd_req_en",    64'(bus.rd_req_en),    64'(m_owner >= 0 && m_age == 1));
    check("busy",         64'(bus.busy),         64'(m_owner >= 0));
    check("rsp_valid",    64'(bus.rsp_valid),    64'(m_rsp));
    check("rsp_data",     64'(bus.rsp_data),     64'(m_rsp_data));
    check("rd_id",        64'(bus.rd_id),        64'(e_id));
    check("rd_base_addr", 64'(bus.rd_base_addr), 64'(e_addr));
    check("rd_len",       64'(bus.rd_len),       64'(e_len));
    check("rd_size",      64'(bus.rd_size),      64'(e_size));
    check("rd_burst",     64'(bus.rd_burst),     64'(e_burst));
    pv = v;
    pr = bus.req_ready;
    @(posedge clk);
    last_granted = -1;
    last_completed = -1;
    m_rsp = '0;
    if (m_owner >= 0 && m_age >= 2 && res_en) begin
      m_rsp[m_owner] = 1'b1;
      m_rsp_data = res_data;
      last_completed = m_owner;
      m_owner = -1;
    end else if (m_owner >= 0) begin
      m_age++;
      if (m_age == 2) m_cnt = $urandom_range(lat_max, lat_min);
    end else if (g >= 0) begin
      m_owner = g; m_age = 1; m_rr = (g + 1) % N;
      e_id = q_id[g]; e_addr = q_addr[g]; e_len = q_len[g];
      e_size = q_size[g]; e_burst = q_burst[g];
      last_granted = g;
    end
    #1;
    if (last_granted >= 0) begin
      grant_q.push_back(last_granted);
      if (cont_mode) begin
        new_rand_req(last_granted);
      end else begin
        v[last_granted] = 1'b0;
        bus.req_valid = v;
      end
    end
    if (rand_arr) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 3) == 0) new_rand_req(i);
      end
    end
  endtask

  task automatic wait_grant(input int who, input int maxc);
    int c = 0;
    last_granted = -1;
    while (last_granted != who && c < maxc) begin
      run_cycle();
      c++;
    end
    check("grant_seen", 64'(last_granted), 64'(who));
  endtask

  task automatic wait_done(input int who, input int maxc);
    int c = 0;
    last_completed = -1;
    while (last_completed != who && c < maxc) begin
      run_cycle();
      c++;
    end
    check("done_seen", 64'(last_completed), 64'(who));
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((v != '0 || m_owner >= 0) && c < maxc) begin
      run_cycle();
      c++;
    end
    check("drain_owner", 64'(m_owner + 1), 64'(0));
    #1;
    check("drain_busy", 64'(bus.busy), 64'(0));
  endtask

  initial begin
    bus.req_id = '0; bus.req_addr = '0; bus.req_len = '0;
    bus.req_size = '0; bus.req_burst = '0; bus.rd_result_data = '0;
    lat_min = 0; lat_max = 2; spur_mode = 0;
    cont_mode = 0; rand_arr = 0; fix_en = 0; fix_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",      64'(bus.busy),         64'(0));
    check("rst_rd_req_en", 64'(bus.rd_req_en),    64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid),    64'(0));
    check("rst_rd_addr",   64'(bus.rd_base_addr), 64'(0));
    rst_n = 1'b1;

    // All four requesting continuously from reset.
    cont_mode = 1;
    for (int i = 0; i < N; i++) new_rand_req(i);
    grant_q.delete();
    for (int c = 0; c < 100 && grant_q.size() < 5; c++) run_cycle();
    check("order_count", 64'(grant_q.size() >= 5), 64'(1));
    for (int k = 0; k < 5 && k < grant_q.size(); k++) begin
      check("order", 64'(grant_q[k]), 64'(exp_order[k]));
    end
    cont_mode = 0;
    drain(200);

    // Single request with fixed controller data.
    set_req(2, 4'h5, 32'h1000, 8'd3, 3'd2, 2'd1);
    #1;
    check("single_ready", 64'(bus.req_ready), 64'(4'b0100));
    fix_en = 1; fix_data = 32'hDEAD_BEEF;
    wait_grant(2, 20);
    #1;
    check("single_issue", 64'(bus.rd_req_en),    64'(1));
    check("single_addr",  64'(bus.rd_base_addr), 64'(32'h1000));
    check("single_len",   64'(bus.rd_len),       64'(3));
    wait_done(2, 20);
    #1;
    check("single_rsp",  64'(bus.rsp_valid), 64'(4'b0100));
    check("single_data", 64'(bus.rsp_data),  64'(32'hDEAD_BEEF));
    fix_en = 0;

    // Fairness: move rr_ptr to 2, then 0 and 1 contend; 0 wins by wrap, then 1.
    new_rand_req(1);
    wait_grant(1, 20);
    wait_done(1, 20);
    new_rand_req(0);
    new_rand_req(1);
    wait_grant(0, 20);
    wait_grant(1, 20);
    wait_done(1, 20);

    // Spurious completions while idle and while issuing are ignored.
    spur_mode = 2;
    repeat (4) run_cycle();
    new_rand_req(3);
    wait_grant(3, 20);
    wait_done(3, 20);
    spur_mode = 0;
    repeat (2) run_cycle();

    // Back-to-back: requester 1 waits behind requester 3.
    new_rand_req(3);
    wait_grant(3, 20);
    new_rand_req(1);
    wait_done(3, 20);
    #1;
    check("b2b_rsp",   64'(bus.rsp_valid), 64'(4'b1000));
    check("b2b_ready", 64'(bus.req_ready), 64'(4'b0010));
    run_cycle();
    #1;
    check("b2b_issue", 64'(bus.rd_req_en), 64'(1));
    wait_done(1, 20);

    // Reset during WAIT discards the transaction.
    lat_min = 10; lat_max = 20;
    new_rand_req(2);
    wait_grant(2, 20);
    run_cycle();
    run_cycle();
    rst_n = 1'b0;
    #1;
    check("mid_busy",      64'(bus.busy),         64'(0));
    check("mid_rd_req_en", 64'(bus.rd_req_en),    64'(0));
    check("mid_rsp_valid", 64'(bus.rsp_valid),    64'(0));
    check("mid_rsp_data",  64'(bus.rsp_data),     64'(0));
    check("mid_rd_addr",   64'(bus.rd_base_addr), 64'(0));
    check("mid_rd_id",     64'(bus.rd_id),        64'(0));
    check("mid_ready",     64'(bus.req_ready),    64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat_min = 0; lat_max = 3;
    repeat (3) run_cycle();
    new_rand_req(3);
    new_rand_req(1);
    wait_grant(1, 20);
    drain(100);

    // Random traffic with spurious completions.
    rand_arr = 1; spur_mode = 1;
    repeat (400) run_cycle();
    rand_arr = 0; spur_mode = 0;
    drain(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
